// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble add/subtract sequencer built around a single 4-bit ripple-carry adder.
// One nibble per cycle, LSB first, with valid/ready handshakes on operands and results.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 sub,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  opa_reg, opb_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  result_reg;
    logic          carry_out_reg, overflow_reg;

    logic          accept, last_nib, run_en;
    logic [3:0]    add_a, add_b, add_s;
    logic          add_co;

    logic [3:0]    a_nib [NIBBLES];
    logic [3:0]    b_nib [NIBBLES];
    logic [W-5:0]  work_lo;

    // Operand nibble views so the adder inputs are a plain mux on the counter.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = opa_reg[4*gi +: 4];
            assign b_nib[gi] = opb_reg[4*gi +: 4];
        end
    endgenerate

    assign add_a = a_nib[cnt_reg];
    assign add_b = b_nib[cnt_reg];

    ripple_carry_adder u_rca (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_reg),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        last_nib    = 1'b0;
        run_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (cnt_reg == LAST_NIB) begin
                    last_nib   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the lower NIBBLES-1 nibbles need storage; the top nibble goes straight
    // from the adder into the result register on the final RUN edge.
    generate
        for (genvar gi = 0; gi < NIBBLES - 1; gi++) begin : g_work
            logic [3:0] nib_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    nib_reg <= 4'h0;
                end else if (run_en && (cnt_reg == CW'(gi))) begin
                    nib_reg <= add_s;
                end
            end
            assign work_lo[4*gi +: 4] = nib_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_reg       <= '0;
            opb_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (accept) begin
                // Subtract is A + ~B + 1: invert B once here and seed the carry with sub.
                opa_reg   <= op_a;
                opb_reg   <= sub ? ~op_b : op_b;
                carry_reg <= sub;
                cnt_reg   <= '0;
            end else if (run_en) begin
                carry_reg <= add_co;
                cnt_reg   <= last_nib ? '0 : cnt_reg + 1'b1;
            end
            if (last_nib) begin
                result_reg    <= {add_s, work_lo};
                carry_out_reg <= add_co;
                overflow_reg  <= (opa_reg[W-1] == opb_reg[W-1]) && (add_s[3] != opa_reg[W-1]);
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
endmodule
